// File: rtl/jtag_probe_mm_pkg.sv
// jtag_probe_mm_pkg: opcodes, header layout, response words and FSM states for jtag_probe_mm_master.
// ST_DRAIN exists only when JPM_TIMEOUT_EN is defined.
package jtag_probe_mm_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_PING  = 2'b11;

  localparam int unsigned HDR_OP_LSB  = 14;
  localparam int unsigned HDR_OP_W    = 2;
  localparam int unsigned HDR_LEN_LSB = 10;
  localparam int unsigned HDR_LEN_W   = 4;

  localparam logic [7:0]  ACK_TAG  = 8'hAC;
  localparam logic [15:0] ERR_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_WR_DATA,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
`ifdef JPM_TIMEOUT_EN
    ST_SEND,
    ST_DRAIN
`else
    ST_SEND
`endif
  } state_t;

endpackage

// File: rtl/jpm_timeout_ctr.sv
// jpm_timeout_ctr: per-transaction cycle counter; expire flags TIMEOUT cycles since the last load/clear.
// Only instantiated when JPM_TIMEOUT_EN is defined.
module jpm_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic arst,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (load || clear) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_probe_mm_master.sv
// jtag_probe_mm_master: executes host command words as single-outstanding mm reads/writes.
// Define JPM_TIMEOUT_EN for a per-transaction timeout that returns ERR_WORD and drains the command.
module jtag_probe_mm_master
  import jtag_probe_mm_pkg::*;
#(
  parameter int                   DAT_WIDTH  = 16,
  parameter int                   ADDR_WIDTH = 16,
  parameter logic [DAT_WIDTH-1:0] PING_ID    = 16'h4A50,
  parameter int                   TIMEOUT    = 1024
) (
  input  logic                  core_clock,
  input  logic                  arst,
  input  logic [DAT_WIDTH-1:0]  dat_from_host,
  input  logic                  dat_from_host_valid,
  output logic                  dat_from_host_ready,
  output logic [DAT_WIDTH-1:0]  dat_to_host,
  output logic                  dat_to_host_valid,
  input  logic                  dat_to_host_ready,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [DAT_WIDTH-1:0]  mm_wdata,
  output logic                  mm_write,
  output logic                  mm_read,
  input  logic                  mm_waitrequest,
  input  logic [DAT_WIDTH-1:0]  mm_rdata,
  input  logic                  mm_rdata_valid
);

  if (DAT_WIDTH != 16) begin : g_bad_dat_width
    $error("jtag_probe_mm_master: DAT_WIDTH must be 16");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
    $error("jtag_probe_mm_master: ADDR_WIDTH must be 1..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("jtag_probe_mm_master: TIMEOUT must be at least 1");
  end

  state_t                 state, state_n;
  logic                   run_q;
  logic [HDR_OP_W-1:0]    op_q, hdr_op;
  logic [HDR_LEN_W-1:0]   len_m1_q, left_q;
  logic [DAT_WIDTH-1:0]   out_q;
  logic                   host_take, expired, to_hit;

  assign hdr_op    = dat_from_host[HDR_OP_LSB +: HDR_OP_W];
  assign host_take = dat_from_host_valid && dat_from_host_ready;

  // Request/valid strobes decode straight from state so arst drops them without waiting for a clock.
  assign mm_write          = (state == ST_WR_ISSUE);
  assign mm_read           = (state == ST_RD_ISSUE);
  assign dat_to_host_valid = (state == ST_SEND);
  assign dat_to_host       = out_q;

`ifdef JPM_TIMEOUT_EN
  logic err_q, timed, tmr_expire;

  assign timed = (state == ST_WR_ISSUE) || (state == ST_RD_ISSUE) || (state == ST_RD_WAIT);

  jpm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (core_clock),
    .arst   (arst),
    .load   (state_n != state),
    .clear  (!timed),
    .expire (tmr_expire)
  );

  assign expired = timed && tmr_expire;
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    dat_from_host_ready = run_q &&
      ((state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_WR_DATA));
`ifdef JPM_TIMEOUT_EN
    if (state == ST_DRAIN && op_q == OP_WRITE && left_q != '0) dat_from_host_ready = 1'b1;
`endif
  end

  always_comb begin
    state_n = state;
    to_hit  = 1'b0;
    case (state)
      ST_IDLE:
        if (host_take) begin
          case (hdr_op)
            OP_PING:           state_n = ST_SEND;
            OP_WRITE, OP_READ: state_n = ST_GET_ADDR;
            OP_NOP:            state_n = ST_IDLE;
            default:           state_n = ST_IDLE;
          endcase
        end
      ST_GET_ADDR:
        if (host_take) state_n = (op_q == OP_WRITE) ? ST_WR_DATA : ST_RD_ISSUE;
      ST_WR_DATA:
        if (host_take) state_n = ST_WR_ISSUE;
      ST_WR_ISSUE:
        if (!mm_waitrequest) begin
          state_n = (left_q != '0) ? ST_WR_DATA : ST_SEND;
        end else if (expired) begin
          state_n = ST_SEND;
          to_hit  = 1'b1;
        end
      ST_RD_ISSUE:
        if (!mm_waitrequest) begin
          state_n = ST_RD_WAIT;
        end else if (expired) begin
          state_n = ST_SEND;
          to_hit  = 1'b1;
        end
      ST_RD_WAIT:
        if (mm_rdata_valid) begin
          state_n = ST_SEND;
        end else if (expired) begin
          state_n = ST_SEND;
          to_hit  = 1'b1;
        end
      ST_SEND:
        if (dat_to_host_ready) begin
`ifdef JPM_TIMEOUT_EN
          if (err_q) state_n = ST_DRAIN;
          else
`endif
          if (op_q == OP_READ && left_q != '0) state_n = ST_RD_ISSUE;
          else                                 state_n = ST_IDLE;
        end
`ifdef JPM_TIMEOUT_EN
      ST_DRAIN:
        if (op_q != OP_WRITE || left_q == '0) state_n = ST_IDLE;
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clock or posedge arst) begin
    if (arst) begin
      state    <= ST_IDLE;
      run_q    <= 1'b0;
      op_q     <= '0;
      len_m1_q <= '0;
      left_q   <= '0;
      out_q    <= '0;
      mm_addr  <= '0;
      mm_wdata <= '0;
`ifdef JPM_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      run_q <= 1'b1;
      if (to_hit) out_q <= ERR_WORD;
`ifdef JPM_TIMEOUT_EN
      if (to_hit) err_q <= 1'b1;
      else if (state == ST_IDLE) err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE:
          if (host_take) begin
            op_q     <= hdr_op;
            len_m1_q <= dat_from_host[HDR_LEN_LSB +: HDR_LEN_W];
            left_q   <= dat_from_host[HDR_LEN_LSB +: HDR_LEN_W];
            if (hdr_op == OP_PING) out_q <= PING_ID;
          end
        ST_GET_ADDR:
          if (host_take) mm_addr <= dat_from_host[ADDR_WIDTH-1:0];
        ST_WR_DATA:
          if (host_take) mm_wdata <= dat_from_host;
        ST_WR_ISSUE:
          if (!mm_waitrequest) begin
            mm_addr <= mm_addr + ADDR_WIDTH'(1);
            if (left_q != '0) left_q <= left_q - HDR_LEN_W'(1);
            else              out_q  <= {ACK_TAG, 4'h0, len_m1_q};
          end
        ST_RD_WAIT:
          if (mm_rdata_valid) out_q <= mm_rdata;
        ST_SEND:
          if (dat_to_host_ready && op_q == OP_READ && left_q != '0) begin
            mm_addr <= mm_addr + ADDR_WIDTH'(1);
            left_q  <= left_q - HDR_LEN_W'(1);
          end
`ifdef JPM_TIMEOUT_EN
        ST_DRAIN:
          if (host_take) left_q <= left_q - HDR_LEN_W'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_probe_mm_master.sv
// tb_jtag_probe_mm_master: randomized scoreboard bench; expected words come from a command-level model.
// Timeout scenarios are exercised only when JPM_TIMEOUT_EN is defined.
module tb_jtag_probe_mm_master;

  localparam int          DW   = 16;
  localparam int          AW   = 16;
  localparam logic [15:0] PING = 16'h4A50;
  localparam int          TO   = 8;

  logic          core_clock = 1'b0;
  logic          arst = 1'b1;
  logic [DW-1:0] dat_from_host = '0;
  logic          dat_from_host_valid = 1'b0;
  logic          dat_from_host_ready;
  logic [DW-1:0] dat_to_host;
  logic          dat_to_host_valid;
  logic          dat_to_host_ready;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_wdata;
  logic          mm_write, mm_read;
  logic          mm_waitrequest;
  logic [DW-1:0] mm_rdata;
  logic          mm_rdata_valid;

  jtag_probe_mm_master #(
    .DAT_WIDTH (DW),
    .ADDR_WIDTH(AW),
    .PING_ID   (PING),
    .TIMEOUT   (TO)
  ) dut (
    .core_clock         (core_clock),
    .arst               (arst),
    .dat_from_host      (dat_from_host),
    .dat_from_host_valid(dat_from_host_valid),
    .dat_from_host_ready(dat_from_host_ready),
    .dat_to_host        (dat_to_host),
    .dat_to_host_valid  (dat_to_host_valid),
    .dat_to_host_ready  (dat_to_host_ready),
    .mm_addr            (mm_addr),
    .mm_wdata           (mm_wdata),
    .mm_write           (mm_write),
    .mm_read            (mm_read),
    .mm_waitrequest     (mm_waitrequest),
    .mm_rdata           (mm_rdata),
    .mm_rdata_valid     (mm_rdata_valid)
  );

  always #5 core_clock = ~core_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mm_t;

  mm_t         mm_exp[$];
  logic [15:0] host_exp[$];
  logic [15:0] wr_data[$];
  logic [15:0] ref_mem[int];
  logic [15:0] slv_mem[int];

  int wait_mode = 0;   // 0 random stalls, 1 two stalls per request, 2 stuck high
  int rdy_mode  = 0;   // 0 random, 1 hold ready low 5 cycles per word
  bit spur_en   = 1'b1;
  int rd_hi     = 0;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] slv_rd(input int a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge core_clock);
      #1;
    end
  endtask

  // Memory slave: checks each accepted request against the scoreboard, returns read data later.
  initial begin : slave
    logic        pend;
    logic [15:0] pend_addr;
    int          pend_dly;
    int          stall_cnt;
    mm_t         e;
    pend = 1'b0; pend_addr = '0; pend_dly = 0; stall_cnt = 0;
    mm_waitrequest = 1'b0; mm_rdata_valid = 1'b0; mm_rdata = '0;
    forever begin
      @(negedge core_clock);
      if (mm_read) begin
        rd_hi++;
        chk("no_read_while_sending", dat_to_host_valid, 1'b0);
        chk("rd_wr_exclusive", mm_write, 1'b0);
      end
      if (mm_read || mm_write) begin
        if (mm_waitrequest) begin
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          chk("mm_req_expected", mm_exp.size() != 0, 1'b1);
          if (mm_exp.size() != 0) begin
            e = mm_exp.pop_front();
            chk("mm_direction", mm_write, e.wr);
            chk("mm_addr", mm_addr, e.addr);
            if (e.wr) chk("mm_wdata", mm_wdata, e.data);
          end
          if (mm_write) begin
            slv_mem[int'(mm_addr)] = mm_wdata;
          end else begin
            pend = 1'b1; pend_addr = mm_addr; pend_dly = $urandom_range(0, 3);
          end
        end
      end
      @(posedge core_clock);
      #1;
      if (arst) begin
        pend = 1'b0;
        stall_cnt = 0;
      end
      case (wait_mode)
        0:       mm_waitrequest = ($urandom % 3 == 0);
        1:       mm_waitrequest = (stall_cnt < 2);
        default: mm_waitrequest = 1'b1;
      endcase
      mm_rdata_valid = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          mm_rdata_valid = 1'b1;
          mm_rdata = slv_rd(int'(pend_addr));
          pend = 1'b0;
        end else begin
          pend_dly--;
        end
      end else if (spur_en && ($urandom % 8 == 0)) begin
        mm_rdata_valid = 1'b1;
        mm_rdata = 16'($urandom);
      end
    end
  end

  initial begin : host_ready
    int low_cnt;
    low_cnt = 0;
    dat_to_host_ready = 1'b0;
    forever begin
      @(posedge core_clock);
      #1;
      if (rdy_mode == 0) begin
        dat_to_host_ready = ($urandom % 4 != 0);
      end else if (dat_to_host_valid && low_cnt < 5) begin
        dat_to_host_ready = 1'b0;
        low_cnt++;
      end else if (dat_to_host_valid) begin
        dat_to_host_ready = 1'b1;
        low_cnt = 0;
      end else begin
        dat_to_host_ready = 1'b0;
      end
    end
  end

  initial begin : host_monitor
    logic [15:0] last_word;
    bit          holding;
    holding = 1'b0; last_word = '0;
    forever begin
      @(negedge core_clock);
      if (dat_to_host_valid) begin
        if (holding) chk("to_host_stable", dat_to_host, last_word);
        if (dat_to_host_ready) begin
          chk("to_host_expected", host_exp.size() != 0, 1'b1);
          if (host_exp.size() != 0) chk("to_host_word", dat_to_host, host_exp.pop_front());
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          last_word = dat_to_host;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int unsigned n;
    n = 0;
    dat_from_host = w;
    dat_from_host_valid = 1'b1;
    @(negedge core_clock);
    while (!dat_from_host_ready && n < 3000) begin
      @(negedge core_clock);
      n++;
    end
    chk("host_word_accepted", dat_from_host_ready, 1'b1);
    @(posedge core_clock);
    #1;
    dat_from_host_valid = 1'b0;
    dat_from_host = 16'($urandom);
  endtask

  // Command-level model: computes the mm transactions and host words a command must produce.
  task automatic run_cmd(input logic [1:0] op, input int unsigned len,
                         input logic [15:0] addr, input logic [9:0] junk);
    logic [3:0]  lm1;
    logic [15:0] a, d;
    logic [15:0] words[$];
    lm1 = 4'(len - 1);
    words.delete();
    case (op)
      2'b11: host_exp.push_back(PING);
      2'b01: begin
        for (int unsigned i = 0; i < len; i++) begin
          a = 16'((32'(addr) + i) % 65536);
          d = (wr_data.size() != 0) ? wr_data.pop_front() : 16'($urandom);
          mm_exp.push_back('{wr: 1'b1, addr: a, data: d});
          ref_mem[int'(a)] = d;
          words.push_back(d);
        end
        host_exp.push_back({8'hAC, 4'h0, lm1});
      end
      2'b10: begin
        for (int unsigned i = 0; i < len; i++) begin
          a = 16'((32'(addr) + i) % 65536);
          mm_exp.push_back('{wr: 1'b0, addr: a, data: 16'h0});
          host_exp.push_back(ref_rd(int'(a)));
        end
      end
      default: ;
    endcase
    send_word({op, lm1, junk});
    if (op == 2'b11) chk("ping_latency", dat_to_host_valid, 1'b1);
    if (op == 2'b00) chk("nop_no_response", dat_to_host_valid, 1'b0);
    if (op == 2'b01 || op == 2'b10) send_word(addr);
    foreach (words[i]) begin
      send_word(words[i]);
      chk("write_latency", mm_write, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((host_exp.size() != 0 || mm_exp.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    chk("responses_in_time", (host_exp.size() == 0) && (mm_exp.size() == 0), 1'b1);
    tick(3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] old;
    tick(3);
    chk("rst_mm_read", mm_read, 1'b0);
    chk("rst_mm_write", mm_write, 1'b0);
    chk("rst_to_host_valid", dat_to_host_valid, 1'b0);
    chk("rst_from_host_ready", dat_from_host_ready, 1'b0);
    chk("rst_mm_addr", mm_addr, 16'h0);
    chk("rst_mm_wdata", mm_wdata, 16'h0);
    chk("rst_to_host", dat_to_host, 16'h0);
    arst = 1'b0;
    tick(2);

    run_cmd(2'b11, 1, 16'h0, 10'h000);           // 16'hC000 ping
    wait_idle();
    run_cmd(2'b00, 1, 16'h0, 10'h3FF);           // 16'h03FF nop
    run_cmd(2'b11, 1, 16'h0, 10'h000);
    wait_idle();

    wait_mode = 1;
    wr_data = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_cmd(2'b01, 4, 16'h0010, 10'h000);        // 16'h4C00
    wait_idle();
    wait_mode = 0;

    ref_mem[16'hFFFF] = 16'hBEEF; slv_mem[16'hFFFF] = 16'hBEEF;
    ref_mem[0]        = 16'hCAFE; slv_mem[0]        = 16'hCAFE;
    rdy_mode = 1;
    run_cmd(2'b10, 2, 16'hFFFF, 10'h000);        // 16'h8400
    wait_idle();
    rdy_mode = 0;

    for (int k = 0; k < 40; k++) begin
      logic [15:0] ra;
      ra = ($urandom % 4 == 0) ? (16'hFFF8 + 16'($urandom % 8)) : 16'($urandom_range(0, 31));
      run_cmd(2'($urandom), $urandom_range(1, 16), ra, 10'($urandom));
      if ($urandom % 4 == 0) tick($urandom_range(1, 4));
    end
    wait_idle();

    wait_mode = 2;
    old = ref_rd(16'h0123);
    run_cmd(2'b01, 1, 16'h0123, 10'h000);
    tick(2);
    chk("write_held_before_reset", mm_write, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk("reset_drops_mm_write", mm_write, 1'b0);
    chk("reset_drops_to_host_valid", dat_to_host_valid, 1'b0);
    mm_exp.delete();
    host_exp.delete();
    ref_mem[16'h0123] = old;
    tick(2);
    arst = 1'b0;
    wait_mode = 0;
    tick(2);
    run_cmd(2'b11, 1, 16'h0, 10'h155);
    wait_idle();

`ifdef JPM_TIMEOUT_EN
    wait_mode = 2;
    spur_en = 1'b0;
    tick(2);
    rd_hi = 0;
    host_exp.push_back(16'hDEAD);
    send_word({2'b10, 4'd1, 10'd0});
    send_word(16'h0040);
    wait_idle();
    chk("timeout_read_cycles", rd_hi, TO);
    host_exp.push_back(16'hDEAD);
    send_word({2'b01, 4'd2, 10'd0});
    send_word(16'h0050);
    send_word(16'h1111);
    send_word(16'hC111);                         // drained, must not act as a ping
    send_word(16'hC222);
    wait_idle();
    wait_mode = 0;
    spur_en = 1'b1;
    run_cmd(2'b11, 1, 16'h0, 10'h000);
    wait_idle();
`endif

    tick(5);
    chk("host_queue_empty", host_exp.size(), 0);
    chk("mm_queue_empty", mm_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
